fetch_queue: RTL and testbench

//  Instruction prefetch buffer between IF stage and IF/ID register: decouples fetch from decode stalls.

---
 rtl/pipeline_pkg.sv | 9 +
 rtl/fetch_queue_mem.sv | 20 ++
 rtl/fetch_queue.sv | 73 +++++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline constants and fetch-queue entry type
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x W register array, one sync write port, one async read port
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  // storage is intentionally not reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID prefetch FIFO with flush; optional FETCH_QUEUE_BYPASS_EN zero-latency bypass when empty
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = pipeline_pkg::XLEN,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instruction,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instruction,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);
  import pipeline_pkg::*;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*XLEN-1:0] rd_data;
  logic byp, push, pop, wr_en, rd_en;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign if_ready = ~full;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & ~flush & if_valid;
`else
  assign byp = 1'b0;
`endif
  assign id_valid = (~empty | byp) & ~flush;
  assign push = if_valid & if_ready;
  assign pop = id_valid & id_ready;
  // a bypassed entry consumed this cycle is never written; pops only drain stored entries
  always_comb begin
    wr_en = push & ~flush & ~(byp & id_ready);
    rd_en = pop & ~empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_en);
    count_d = flush ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
  end
  // pointer and occupancy state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  fetch_queue_mem #(.DEPTH(DEPTH), .W(2*XLEN)) u_mem (
    .clk(clk),
    .we(wr_en),
    .waddr(wr_ptr_q),
    .wdata({if_pc, if_instruction}),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );
  // head output: bypass, then stored head, else a NOP bubble when empty
  always_comb begin
    id_pc = byp ? if_pc : empty ? '0 : rd_data[2*XLEN-1:XLEN];
    id_instruction = byp ? if_instruction : empty ? XLEN'(NOP_INSTR) : rd_data[XLEN-1:0];
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (directed vectors)
module tb_fetch_queue;
  logic clk = 0, rst = 1, flush = 0, if_valid = 0, id_ready = 0;
  logic [31:0] if_pc = 0, if_instruction = 0;
  logic if_ready, id_valid, full, empty;
  logic [31:0] id_pc, id_instruction;
  logic [2:0] count;
  int errors = 0, checks = 0;
  logic [31:0] exp_pc_q[$];
  always #5 clk = ~clk;
  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instruction(if_instruction),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instruction(id_instruction),
    .count(count), .full(full), .empty(empty)
  );
  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic v, logic [31:0] pc);
    if_valid = v;
    if_pc = pc;
    if_instruction = instr_of(pc);
  endtask
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_pc_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pop: got pc %h expected no output", id_pc);
      end else begin
        logic [31:0] e;
        e = exp_pc_q.pop_front();
        chk("pop_pc", id_pc, e);
        chk("pop_instr", id_instruction, instr_of(e));
      end
    end
  end
  initial begin
    repeat (2) cyc();
    rst = 0;
    cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_if_ready", 32'(if_ready), 1);
    chk("empty_id_pc", id_pc, 0);
    chk("empty_id_instr", id_instruction, 32'h00000013);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(4*i));
      cyc();
    end
    drive(0, 0);
    chk("t1_count3", 32'(count), 3);
    #2 rst = 1;
    #1;
    chk("t1_async_count", 32'(count), 0);
    chk("t1_async_empty", 32'(empty), 1);
    chk("t1_async_id_valid", 32'(id_valid), 0);
    cyc();
    rst = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(4*i));
      exp_pc_q.push_back(32'(4*i));
      cyc();
    end
    chk("t2_full", 32'(full), 1);
    chk("t2_if_ready", 32'(if_ready), 0);
    chk("t2_count", 32'(count), 4);
    drive(1, 32'h30);
    cyc();
    drive(0, 0);
    chk("t2_fifth_ignored", 32'(count), 4);
    id_ready = 1;
    repeat (2) cyc();
    id_ready = 0;
    chk("t3_count_after_pop2", 32'(count), 2);
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h10 + 32'(4*i));
      exp_pc_q.push_back(32'h10 + 32'(4*i));
      cyc();
    end
    drive(0, 0);
    chk("t3_count_refill", 32'(count), 4);
    id_ready = 1;
    repeat (4) cyc();
    id_ready = 0;
    chk("t3_drained", 32'(count), 0);
    chk("t3_empty", 32'(empty), 1);
    drive(1, 32'h50); exp_pc_q.push_back(32'h50); cyc();
    drive(1, 32'h54); exp_pc_q.push_back(32'h54); cyc();
    chk("t4_count2", 32'(count), 2);
    drive(1, 32'h20); exp_pc_q.push_back(32'h20);
    id_ready = 1;
    cyc();
    drive(0, 0);
    id_ready = 0;
    chk("t4_count_stays", 32'(count), 2);
    chk("t4_head_advanced", id_pc, 32'h54);
    id_ready = 1;
    repeat (2) cyc();
    id_ready = 0;
    chk("t4_drained", 32'(count), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h60 + 32'(4*i));
      cyc();
    end
    chk("t5_count3", 32'(count), 3);
    drive(1, 32'h40);
    flush = 1;
    id_ready = 1;
    #1;
    chk("t5_flush_id_valid", 32'(id_valid), 0);
    cyc();
    flush = 0;
    drive(0, 0);
    id_ready = 0;
    #1;
    chk("t5_flush_count", 32'(count), 0);
    chk("t5_flush_empty", 32'(empty), 1);
    drive(1, 32'h80); exp_pc_q.push_back(32'h80); cyc();
    drive(0, 0);
    chk("t5_next_valid", 32'(id_valid), 1);
    chk("t5_next_pc", id_pc, 32'h80);
    id_ready = 1;
    cyc();
    id_ready = 0;
    chk("t6_empty_pc", id_pc, 0);
    chk("t6_empty_instr", id_instruction, 32'h00000013);
`ifdef FETCH_QUEUE_BYPASS_EN
    drive(1, 32'h100);
    id_ready = 1;
    exp_pc_q.push_back(32'h100);
    #1;
    chk("t6_byp_valid", 32'(id_valid), 1);
    chk("t6_byp_pc", id_pc, 32'h100);
    cyc();
    drive(0, 0);
    id_ready = 0;
    chk("t6_byp_count", 32'(count), 0);
`endif
    cyc();
    chk("scoreboard_empty", 32'(exp_pc_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
